// File: rtl/duram_fifo_ctrl.sv
// Single-clock FIFO controller driving an external dual-port RAM.
// Port A of the RAM is the write side and port B is the read side; the RAM read has one cycle of latency.
module duram_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned AFULL_LEVEL  = 2**ADDR_WIDTH - 4,
  parameter int unsigned AEMPTY_LEVEL = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0]      CNT_ONE = 1;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      count_next;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses the flags from the registered count, so a full FIFO
  // never takes a write even when a read frees a slot in the same cycle.
  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AFULL_LEVEL));
  assign almost_empty = (count <= CNT_W'(AEMPTY_LEVEL));

  assign ram_wren  = wr_acc;
  assign ram_waddr = wr_ptr;
  assign ram_wdata = wr_data;
  assign ram_raddr = rd_ptr;
  assign rd_data   = ram_q;

  always_comb begin
    // NOTE: default assignment first so no latch is inferred on the hold path.
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // The RAM array lives outside this block and keeps its contents across
  // reset and flush; clearing the pointers alone makes old words unreachable.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      count     <= count_next;
      rd_valid  <= rd_acc;
      overflow  <= overflow  | (wr_en & full);
      underflow <= underflow | (rd_en & empty);
    end
  end

endmodule
